// File: rtl/mem_bneck_ctrl.sv
// Single-port arbiter/sequencer for the 16-lane bottleneck feature-map memory.
// Optional stall counters are enabled by defining MEM_BNECK_CTRL_PERF_EN.
module mem_bneck_ctrl #(
    parameter int BITSIZE    = 16,
    parameter int HEIGHT     = 12544,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [13:0]             cfg_pixels,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [BITSIZE*16-1:0]   wr_data,
    input  logic                    rd_req,
    output logic                    rd_gnt,
    output logic                    rd_data_valid,
    output logic [BITSIZE*16-1:0]   rd_data,
    output logic [13:0]             mem_index,
    output logic                    mem_en,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [BITSIZE*16-1:0]   mem_data_in,
    input  logic [BITSIZE*16-1:0]   mem_data_out
`ifdef MEM_BNECK_CTRL_PERF_EN
    ,
    output logic [15:0]             perf_wr_stall,
    output logic [15:0]             perf_rd_stall
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [13:0] MAX_PIX = 14'(HEIGHT);

    state_t                  state, state_nx;
    logic [13:0]             npix, wr_cnt, rd_cnt, idx_q;
    logic                    prio_rd, err_q;
    logic [RD_LATENCY-1:0]   vpipe;

    logic in_run, wr_elig, rd_elig, wr_gnt, rd_gnt_i, cfg_ok, start_ok;

    assign in_run   = (state == S_RUN);
    assign wr_elig  = in_run && wr_valid && (wr_cnt < npix);
    // Compare against the write count at cycle start: no same-cycle bypass.
    assign rd_elig  = in_run && rd_req && (rd_cnt < wr_cnt);
    assign wr_gnt   = wr_elig && (!rd_elig || !prio_rd);
    assign rd_gnt_i = rd_elig && (!wr_elig || prio_rd);
    assign cfg_ok   = (cfg_pixels != 14'd0) && (cfg_pixels <= MAX_PIX);
    assign start_ok = (state == S_IDLE) && cfg_start && cfg_ok;

    assign busy          = (state != S_IDLE);
    assign cfg_err       = err_q;
    assign wr_ready      = wr_gnt;
    assign rd_gnt        = rd_gnt_i;
    assign mem_en        = wr_gnt || rd_gnt_i;
    assign mem_wr        = wr_gnt;
    assign mem_rd        = rd_gnt_i;
    assign mem_index     = wr_gnt ? wr_cnt : (rd_gnt_i ? rd_cnt : idx_q);
    assign mem_data_in   = wr_gnt ? wr_data : '0;
    assign rd_data_valid = vpipe[RD_LATENCY-1];
    assign rd_data       = rd_data_valid ? mem_data_out : '0;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nx = state;
        done     = 1'b0;
        case (state)
            S_IDLE:  if (start_ok) state_nx = S_RUN;
            S_RUN:   if (wr_cnt == npix && rd_cnt == npix) state_nx = S_DRAIN;
            S_DRAIN: if (vpipe == '0) begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            npix    <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            idx_q   <= '0;
            prio_rd <= 1'b0;
            err_q   <= 1'b0;
            vpipe   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state <= state_nx;
            err_q <= (state == S_IDLE) && cfg_start && !cfg_ok;
            vpipe <= (vpipe << 1) | RD_LATENCY'(rd_gnt_i);
            if (mem_en) idx_q <= mem_index;
            if (start_ok) begin
                npix    <= cfg_pixels;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                prio_rd <= 1'b0;
            end else begin
                if (wr_gnt)   wr_cnt <= wr_cnt + 14'd1;
                if (rd_gnt_i) rd_cnt <= rd_cnt + 14'd1;
                // Only contested cycles move the round-robin pointer.
                if (wr_elig && rd_elig) prio_rd <= wr_gnt;
            end
        end
    end

`ifdef MEM_BNECK_CTRL_PERF_EN
    logic wr_stall, rd_stall;

    assign wr_stall = wr_elig && !wr_gnt;
    assign rd_stall = in_run && rd_req && (rd_cnt < npix) && !rd_gnt_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_wr_stall <= '0;
            perf_rd_stall <= '0;
        end else if (start_ok) begin
            perf_wr_stall <= '0;
            perf_rd_stall <= '0;
        end else begin
            if (wr_stall && perf_wr_stall != 16'hFFFF) perf_wr_stall <= perf_wr_stall + 16'd1;
            if (rd_stall && perf_rd_stall != 16'hFFFF) perf_rd_stall <= perf_rd_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bneck_ctrl.sv
// Directed self-checking bench for mem_bneck_ctrl with a 1-cycle-latency memory model.
module tb_mem_bneck_ctrl;

    localparam int BITSIZE = 16;
    localparam int HEIGHT  = 12544;
    localparam int RD_LAT  = 1;
    localparam int DW      = BITSIZE * 16;

    logic            clk, rst;
    logic            cfg_start;
    logic [13:0]     cfg_pixels;
    logic            busy, done, cfg_err;
    logic            wr_valid, wr_ready;
    logic [DW-1:0]   wr_data;
    logic            rd_req, rd_gnt, rd_data_valid;
    logic [DW-1:0]   rd_data;
    logic [13:0]     mem_index;
    logic            mem_en, mem_rd, mem_wr;
    logic [DW-1:0]   mem_data_in, mem_data_out;
`ifdef MEM_BNECK_CTRL_PERF_EN
    logic [15:0]     perf_wr_stall, perf_rd_stall;
`endif

    mem_bneck_ctrl #(.BITSIZE(BITSIZE), .HEIGHT(HEIGHT), .RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_pixels(cfg_pixels),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .mem_index(mem_index), .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
`ifdef MEM_BNECK_CTRL_PERF_EN
        , .perf_wr_stall(perf_wr_stall), .perf_rd_stall(perf_rd_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read (one cycle of latency).
    logic [DW-1:0] mem [0:HEIGHT-1];
    logic [DW-1:0] mem_q;
    always @(posedge clk) begin
        if (mem_en && mem_wr) mem[mem_index] <= mem_data_in;
        if (mem_en && mem_rd) mem_q <= mem[mem_index];
    end
    assign mem_data_out = mem_q;

    int n_checks = 0;
    int n_errs   = 0;
    int wr_k, salt;
    logic g_wr;

    always @(negedge clk) g_wr = wr_ready;

    function automatic logic [DW-1:0] pat(input int k, input int s);
        logic [15:0] v;
        v = 16'(k + s * 1000);
        return {16{v}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge; the producer advances on acceptance.
    task automatic advance();
        @(posedge clk);
        #1;
        if (g_wr) wr_k++;
        wr_data = pat(wr_k, salt);
    endtask

    task automatic new_frame(input int n, input int s);
        salt       = s;
        wr_k       = 0;
        wr_data    = pat(0, s);
        cfg_start  = 1'b1;
        cfg_pixels = 14'(n);
        @(posedge clk);
        #1;
        cfg_start  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        string seq;
        int ew, er, nw, nr, nv, bad, last_idx, bad_idx, prev_rd, spurious;
        logic got_done;

        rst = 1'b0; cfg_start = 1'b0; cfg_pixels = '0;
        wr_valid = 1'b0; rd_req = 1'b0; wr_data = '0; wr_k = 0; salt = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_index", mem_index, 0);
        check("rst_rd_valid", rd_data_valid, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: four back-to-back writes, then the write side closes.
        wr_valid = 1'b1;
        new_frame(4, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t1_wr_ready", wr_ready, 1);
            check("t1_mem_wr", mem_wr, 1);
            check("t1_index", mem_index, 14'(c));
            check("t1_wdata", mem_data_in, pat(c, 1));
            advance();
        end
        @(negedge clk);
        check("t1_wr_closed", wr_ready, 0);
        check("t1_mem_en_idle", mem_en, 0);
        check("t1_busy", busy, 1);
        check("t1_index_hold", mem_index, 3);
        advance();

        // 2: drain the four pixels by reads, then done.
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check("t2_rd_gnt", rd_gnt, 1);
            check("t2_mem_rd", mem_rd, 1);
            check("t2_index", mem_index, 14'(r));
            check("t2_valid", rd_data_valid, (r > 0) ? 1 : 0);
            if (r > 0) check("t2_rdata", rd_data, pat(r - 1, 1));
            advance();
        end
        @(negedge clk);
        check("t2_no_extra_gnt", rd_gnt, 0);
        check("t2_last_valid", rd_data_valid, 1);
        check("t2_last_rdata", rd_data, pat(3, 1));
        check("t2_done_early", done, 0);
        advance();
        rd_req = 1'b0;
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_valid_gone", rd_data_valid, 0);
        advance();
        @(negedge clk);
        check("t2_done_pulse", done, 0);
        check("t2_busy_low", busy, 0);
        advance();

        // 3: both sides always requesting; round-robin after the first write.
        seq = "WWRWRWRWRWRWRWRR";
        ew = 0; er = 0; prev_rd = -1;
        wr_valid = 1'b1;
        rd_req   = 1'b1;
        new_frame(8, 2);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check("t3_wr_gnt", wr_ready, (seq[c] == "W") ? 1 : 0);
            check("t3_rd_gnt", rd_gnt, (seq[c] == "R") ? 1 : 0);
            check("t3_index", mem_index, (seq[c] == "W") ? 14'(ew) : 14'(er));
            check("t3_valid", rd_data_valid, (prev_rd >= 0) ? 1 : 0);
            if (prev_rd >= 0) check("t3_rdata", rd_data, pat(prev_rd, 2));
            check("t3_done_early", done, 0);
            if (seq[c] == "W") begin
                ew++;
                prev_rd = -1;
            end else begin
                prev_rd = er;
                er++;
            end
            advance();
        end
        @(negedge clk);
        check("t3_last_rdata", rd_data, pat(7, 2));
        check("t3_no_grant", mem_en, 0);
        check("t3_done_early2", done, 0);
        advance();
        @(negedge clk);
        check("t3_done", done, 1);
        advance();
        @(negedge clk);
        check("t3_busy_low", busy, 0);
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        advance();

        // 4: illegal pixel counts raise cfg_err one cycle later and never start.
        for (int k = 0; k < 2; k++) begin
            cfg_start  = 1'b1;
            cfg_pixels = (k == 0) ? 14'd0 : 14'd12545;
            wr_valid   = 1'b1;
            @(negedge clk);
            check("t4_err_early", cfg_err, 0);
            advance();
            cfg_start = 1'b0;
            @(negedge clk);
            check("t4_err", cfg_err, 1);
            check("t4_idle", busy, 0);
            check("t4_no_strobe", mem_en, 0);
            advance();
            @(negedge clk);
            check("t4_err_pulse", cfg_err, 0);
            check("t4_still_idle", busy, 0);
            advance();
        end
        wr_valid = 1'b0;

        // 5: full-depth frame with an ignored mid-frame start.
        nw = 0; bad = 0; bad_idx = 0; last_idx = -1;
        wr_valid = 1'b1;
        new_frame(HEIGHT, 3);
        for (int c = 0; c < HEIGHT + 50 && nw < HEIGHT; c++) begin
            @(negedge clk);
            if (mem_index >= 14'(HEIGHT)) bad_idx++;
            if (wr_ready) begin
                if (mem_index != 14'(nw)) bad++;
                if (mem_data_in != pat(nw, 3)) bad++;
                last_idx = int'(mem_index);
                nw++;
            end
            advance();
            cfg_start  = (c == 100);
            cfg_pixels = 14'd5;
        end
        cfg_start = 1'b0;
        @(negedge clk);
        check("t5_writes", nw, HEIGHT);
        check("t5_last_index", last_idx, 12543);
        check("t5_wr_closed", wr_ready, 0);
        check("t5_busy", busy, 1);
        advance();
        nr = 0; nv = 0; got_done = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        for (int c = 0; c < HEIGHT + 50 && !got_done; c++) begin
            @(negedge clk);
            if (mem_index >= 14'(HEIGHT)) bad_idx++;
            if (rd_gnt) begin
                if (mem_index != 14'(nr)) bad++;
                nr++;
            end
            if (rd_data_valid) begin
                if (rd_data != pat(nv, 3)) bad++;
                nv++;
            end
            if (done) got_done = 1'b1;
            advance();
        end
        rd_req = 1'b0;
        check("t5_reads", nr, HEIGHT);
        check("t5_valids", nv, HEIGHT);
        check("t5_done_seen", got_done, 1);
        check("t5_bad_data", bad, 0);
        check("t5_index_range", bad_idx, 0);
        @(negedge clk);
        check("t5_busy_low", busy, 0);
        advance();

        // 6: reset in the middle of a read burst.
        wr_valid = 1'b1;
        new_frame(4, 4);
        repeat (4) advance();
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        @(negedge clk);
        check("t6_rd0_gnt", rd_gnt, 1);
        check("t6_rd0_index", mem_index, 0);
        advance();
        @(negedge clk);
        check("t6_rd1_index", mem_index, 1);
        rst = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_rd_gnt", rd_gnt, 0);
        check("t6_mem_en", mem_en, 0);
        check("t6_mem_rd", mem_rd, 0);
        check("t6_index", mem_index, 0);
        check("t6_valid", rd_data_valid, 0);
        check("t6_rdata", rd_data, 0);
        check("t6_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_data_valid || done || mem_en || busy) spurious++;
            advance();
        end
        check("t6_quiet_after_rst", spurious, 0);
        rd_req   = 1'b0;
        wr_valid = 1'b1;
        new_frame(2, 5);
        @(negedge clk);
        check("t6_restart_wr", wr_ready, 1);
        check("t6_restart_index", mem_index, 0);
        check("t6_restart_data", mem_data_in, pat(0, 5));
        advance();
        wr_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
